muldiv_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit that sits next to the single-cycle ALU in execute.

---
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one op in flight, fixed latency.
// Ports:
//   clk, rst_n (sync, active-low), flush (kills in-flight/held op)
//   in_valid/in_ready, in_op (funct3), in_a, in_b, in_tag   : request side
//   out_valid/out_ready, out_result, out_tag                : result side
//   busy                                                    : high in BUSY or DONE
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned BPC   = 1,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned N     = XLEN / BPC;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned PW    = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  out_result_d;
    logic [TAG_W-1:0] out_tag_d;

    // Operand decode at accept
    logic            a_sgn, b_sgn, sa, sb, is_div, b_zero, ovf, special, accept;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        a_sgn   = (in_op == 3'd1) | (in_op == 3'd2) | (in_op == 3'd4) | (in_op == 3'd6);
        b_sgn   = (in_op == 3'd1) | (in_op == 3'd4) | (in_op == 3'd6);
        sa      = a_sgn & in_a[XLEN-1];
        sb      = b_sgn & in_b[XLEN-1];
        mag_a   = sa ? -in_a : in_a;
        mag_b   = sb ? -in_b : in_b;
        is_div  = in_op[2];
        b_zero  = (in_b == '0);
        ovf     = is_div & ~in_op[0] & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (&in_b);
        special = is_div & (b_zero | ovf);
        // div-by-zero: quotient all ones, remainder = a; overflow: quotient = a (MIN), remainder 0
        if (b_zero) spec_res = in_op[1] ? in_a : '1;
        else        spec_res = in_op[1] ? '0 : in_a;
    end

    // One BUSY cycle of the magnitude core: BPC shift-add or restoring-divide steps
    logic [PW-1:0]   acc_n, mc_n;
    logic [XLEN-1:0] mp_n;
    logic [XLEN:0]   rem_t;

    always_comb begin
        acc_n = acc_q;
        mc_n  = mcand_q;
        mp_n  = mplier_q;
        rem_t = '0;
        for (int unsigned k = 0; k < BPC; k++) begin
            if (!op_q[2]) begin
                if (mp_n[0]) acc_n = acc_n + mc_n;
                mc_n = mc_n << 1;
                mp_n = mp_n >> 1;
            end else begin
                // mp_n shifts dividend bits out of the top and quotient bits in at the bottom
                rem_t = {acc_n[XLEN-1:0], mp_n[XLEN-1]};
                mp_n  = mp_n << 1;
                if (rem_t >= {1'b0, mcand_q[XLEN-1:0]}) begin
                    rem_t   = rem_t - {1'b0, mcand_q[XLEN-1:0]};
                    mp_n[0] = 1'b1;
                end
                acc_n = {{XLEN{1'b0}}, rem_t[XLEN-1:0]};
            end
        end
    end

    // Sign fix-up and result select, used on the last BUSY cycle
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] quo, rem, fin_res;

    always_comb begin
        prod = neg_q ? -acc_n : acc_n;
        quo  = neg_q ? -mp_n : mp_n;
        rem  = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        case (op_q)
            3'd0:                fin_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin_res = prod[PW-1:XLEN];
            3'd4, 3'd5:          fin_res = quo;
            default:             fin_res = rem;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        neg_d        = neg_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        tag_d        = tag_q;
        out_result_d = out_result;
        out_tag_d    = out_tag;

        case (state_q)
            S_IDLE: ;
            S_BUSY: begin
                acc_d    = acc_n;
                mcand_d  = mc_n;
                mplier_d = mp_n;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d      = S_DONE;
                    out_result_d = fin_res;
                    out_tag_d    = tag_q;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op_d  = in_op;
            neg_d = (in_op[2] & in_op[1]) ? sa : (sa ^ sb);
            tag_d = in_tag;
            cnt_d = CNT_W'(N - 1);
            acc_d = '0;
            if (is_div) begin
                mplier_d = mag_a;
                mcand_d  = {{XLEN{1'b0}}, mag_b};
            end else begin
                mplier_d = mag_b;
                mcand_d  = {{XLEN{1'b0}}, mag_a};
            end
            if (special) begin
                state_d      = S_DONE;
                out_result_d = spec_res;
                out_tag_d    = in_tag;
            end else begin
                state_d = S_BUSY;
            end
        end

        if (flush) state_d = S_IDLE;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            tag_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            tag_q      <= tag_d;
            out_result <= out_result_d;
            out_tag    <= out_tag_d;
            out_valid  <= (state_d == S_DONE);
            busy       <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (BPC=1,2,4) at XLEN=32, directed and random ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        in_valid_v  [3];
    logic        out_ready_v [3];
    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic        busy_v      [3];
    logic [31:0] res_v       [3];
    logic [4:0]  otag_v      [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        muldiv_unit #(.XLEN(32), .BPC(1 << g), .TAG_W(5)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .in_valid   (in_valid_v[g]),
            .in_ready   (in_ready_v[g]),
            .in_op      (in_op),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_tag     (in_tag),
            .out_valid  (out_valid_v[g]),
            .out_ready  (out_ready_v[g]),
            .out_result (res_v[g]),
            .out_tag    (otag_v[g]),
            .busy       (busy_v[g])
        );
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;
    vec_t tv [12];

    // Reference model: plain 64-bit arithmetic on the RISC-V M rules
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return '1;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int ref_lat(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return (32 >> idx) + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // Present an op and let the accept edge pass; inputs are scrambled afterwards
    task automatic start(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        in_op = op; in_a = a; in_b = b; in_tag = tag;
        in_valid_v[idx] = 1'b1;
        #1;
        chk("in_ready before accept", 32'(in_ready_v[idx]), 32'd1);
        @(posedge clk); #1;
        in_valid_v[idx] = 1'b0;
        in_op  = 3'($urandom);
        in_a   = $urandom;
        in_b   = $urandom;
        in_tag = 5'($urandom);
    endtask

    // Count edges from accept until out_valid, then check latency, result, tag
    task automatic wait_done(input int idx, input int exp_lat, input logic [31:0] exp_res, input logic [4:0] exp_tag, input string nm);
        int lat;
        lat = 1;
        while (out_valid_v[idx] !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " result"}, res_v[idx], exp_res);
        chk({nm, " tag"}, 32'(otag_v[idx]), 32'(exp_tag));
    endtask

    task automatic retire(input int idx);
        out_ready_v[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[idx] = 1'b0;
        chk("out_valid after retire", 32'(out_valid_v[idx]), 32'd0);
    endtask

    task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp_res, input string nm);
        start(idx, op, a, b, tag);
        wait_done(idx, ref_lat(idx, op, a, b), exp_res, tag, nm);
        retire(idx);
    endtask

    initial begin
        int          seen;
        logic [31:0] exp_hold;

        tv[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tv[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tv[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tv[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        tv[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        tv[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        tv[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        tv[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        tv[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        tv[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        tv[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tv[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

        rst_n = 1'b0; flush = 1'b0;
        in_op = 3'd0; in_a = '0; in_b = '0; in_tag = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i] = 1'b0;
            out_ready_v[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset out_valid", 32'(out_valid_v[i]), 32'd0);
            chk("reset out_result", res_v[i], 32'd0);
            chk("reset out_tag", 32'(otag_v[i]), 32'd0);
            chk("reset busy", 32'(busy_v[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on BPC=1 (first one carries tag 3, latency 33)
        for (int i = 0; i < 12; i++) begin
            run_op(0, tv[i].op, tv[i].a, tv[i].b, 5'(i + 3), tv[i].r, $sformatf("dir%0d", i));
        end

        // Divide vectors on BPC=2 and BPC=4 (latency 17 and 9)
        for (int d = 1; d < 3; d++) begin
            for (int i = 4; i < 8; i++) begin
                run_op(d, tv[i].op, tv[i].a, tv[i].b, 5'(i), tv[i].r, $sformatf("bpc%0d_dir%0d", 1 << d, i));
            end
        end

        // Random ops against the reference model
        for (int i = 0; i < 45; i++) begin
            int          idx, m;
            logic [2:0]  op;
            logic [31:0] a, b;
            idx = i % 3;
            op  = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            m   = $urandom_range(0, 7);
            if (m == 0) b = 32'd0;
            else if (m == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (m == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
            run_op(idx, op, a, b, 5'($urandom), ref_res(op, a, b), $sformatf("rnd%0d op%0d", i, op));
        end

        // Hold in DONE, no overlap while BUSY, then back-to-back accept
        start(0, 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd11);
        out_ready_v[0] = 1'b1;
        #1;
        chk("busy in BUSY", 32'(busy_v[0]), 32'd1);
        chk("in_ready in BUSY with out_ready", 32'(in_ready_v[0]), 32'd0);
        out_ready_v[0] = 1'b0;
        exp_hold = ref_res(3'd1, 32'h1234_5678, 32'hFEDC_BA98);
        wait_done(0, 33, exp_hold, 5'd11, "hold");
        for (int c = 0; c < 5; c++) begin
            chk("hold out_valid", 32'(out_valid_v[0]), 32'd1);
            chk("hold out_result", res_v[0], exp_hold);
            chk("hold out_tag", 32'(otag_v[0]), 32'd11);
            chk("hold in_ready", 32'(in_ready_v[0]), 32'd0);
            @(posedge clk); #1;
        end
        in_op = 3'd5; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd9;
        in_valid_v[0] = 1'b1;
        out_ready_v[0] = 1'b1;
        #1;
        chk("b2b in_ready", 32'(in_ready_v[0]), 32'd1);
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        in_a = $urandom; in_b = $urandom;
        chk("b2b busy", 32'(busy_v[0]), 32'd1);
        chk("b2b old retired", 32'(out_valid_v[0]), 32'd0);
        wait_done(0, 33, 32'd14, 5'd9, "b2b");
        retire(0);

        // Flush in BUSY cycle 10
        start(0, 3'd0, 32'd77, 32'd99, 5'd21);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid_v[0] = 1'b0;
        chk("flush out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("flush busy", 32'(busy_v[0]), 32'd0);
        chk("flush in_ready", 32'(in_ready_v[0]), 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid_v[0] === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("flushed op never valid", 32'(seen), 32'd0);

        // Flush in IDLE with in_valid: not accepted
        in_op = 3'd5; in_a = 32'd5; in_b = 32'd0;
        flush = 1'b1;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid_v[0] = 1'b0;
        chk("flush idle busy", 32'(busy_v[0]), 32'd0);
        chk("flush idle out_valid", 32'(out_valid_v[0]), 32'd0);

        // Reset mid-op clears everything
        start(0, 3'd4, 32'd1000, 32'd3, 5'd17);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("midrst out_result", res_v[0], 32'd0);
        chk("midrst out_tag", 32'(otag_v[0]), 32'd0);
        chk("midrst busy", 32'(busy_v[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
